// File: rtl/dds_pkg.sv
// ============================================================================
// dds_pkg : shared constants, FSM encoding and SAR helper for the PWM SAR ADC
// Rev 1.0
// ============================================================================
`default_nettype none

package dds_pkg;

  localparam int PWM_PERIOD = 256;
  localparam int ADC_BITS   = 8;
  localparam int CNT_W      = $clog2(PWM_PERIOD);
  localparam int BIT_IDX_W  = $clog2(ADC_BITS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } sar_state_e;

  typedef logic [ADC_BITS-1:0] code_t;

  // Keep or drop the bit under trial depending on the comparator decision.
  function automatic code_t sar_resolve(input code_t trial,
                                        input logic [BIT_IDX_W-1:0] idx,
                                        input logic keep);
    code_t mask;
    mask = code_t'(1) << idx;
    return keep ? trial : (trial & ~mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_gen.sv
// ============================================================================
// pwm_gen : free-running PWM counter with period-aligned shadow duty register
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_gen
  import dds_pkg::*;
(
  input  logic             iclk,
  input  logic             irstn,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pwm_o,
  output logic             period_end_o
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] duty_sh_q;

  // Duty is only captured on the last count so every period is whole.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      cnt_q     <= '0;
      duty_sh_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (period_end_o) begin
        duty_sh_q <= duty_i;
      end
    end
  end

  assign period_end_o = (cnt_q == C_CNT_LAST);
  assign pwm_o        = (cnt_q < duty_sh_q);

endmodule

`default_nettype wire

// File: rtl/pwm_sar_adc.sv
// ============================================================================
// pwm_sar_adc : successive-approximation ADC using a PWM DAC + ext comparator
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_sar_adc
  import dds_pkg::*;
#(
  parameter int SETTLE_PERIODS = 16  // legal 1..255
) (
  input  logic                iclk,
  input  logic                irstn,
  input  logic                ienable,
  input  logic                icomp,
  output logic                opwm,
  output logic [ADC_BITS-1:0] pwm_adc_out,
  output logic                odone,
  output logic                obusy
);

  localparam logic [7:0]           C_LAST_PER = 8'(SETTLE_PERIODS - 1);
  localparam logic [BIT_IDX_W-1:0] C_TOP_IDX  = BIT_IDX_W'(ADC_BITS - 1);
  localparam code_t                C_MSB      = code_t'(1) << (ADC_BITS - 1);

  sar_state_e           state_q, state_d;
  code_t                trial_q, trial_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           per_cnt_q, per_cnt_d;
  code_t                result_q, result_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 sync1_q, comp_s_q;

  logic                 w_period_end;
  logic                 w_sample;
  code_t                w_decided;
  code_t                w_duty;

  pwm_gen u_pwm (
    .iclk         (iclk),
    .irstn        (irstn),
    .duty_i       (w_duty),
    .pwm_o        (opwm),
    .period_end_o (w_period_end)
  );

  assign w_sample  = w_period_end && (per_cnt_q == C_LAST_PER);
  assign w_decided = sar_resolve(trial_q, bit_idx_q, comp_s_q);

  always_comb begin
    state_d   = state_q;
    trial_d   = trial_q;
    bit_idx_d = bit_idx_q;
    per_cnt_d = per_cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ienable && w_period_end) begin
          state_d   = ST_CONV;
          trial_d   = C_MSB;
          bit_idx_d = C_TOP_IDX;
          per_cnt_d = '0;
        end
      end
      ST_CONV: begin
        if (w_sample && (bit_idx_q == '0)) begin
          // Final bit resolved: a completed conversion is always published.
          result_d = w_decided;
          done_d   = 1'b1;
          if (ienable) begin
            trial_d   = C_MSB;
            bit_idx_d = C_TOP_IDX;
            per_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!ienable) begin
          state_d = ST_IDLE;
        end else if (w_sample) begin
          trial_d   = w_decided | (code_t'(1) << (bit_idx_q - BIT_IDX_W'(1)));
          bit_idx_d = bit_idx_q - BIT_IDX_W'(1);
          per_cnt_d = '0;
        end else if (w_period_end) begin
          per_cnt_d = per_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CONV);
  end

  // Next-state view so the shadow register captures the new trial on the
  // same edge the FSM moves to it; the filter tracks the result when idle.
  assign w_duty = (state_d == ST_CONV) ? trial_d : result_d;

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      state_q   <= ST_IDLE;
      trial_q   <= '0;
      bit_idx_q <= '0;
      per_cnt_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sync1_q   <= 1'b0;
      comp_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      trial_q   <= trial_d;
      bit_idx_q <= bit_idx_d;
      per_cnt_q <= per_cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      sync1_q   <= icomp;
      comp_s_q  <= sync1_q;
    end
  end

  assign pwm_adc_out = result_q;
  assign odone       = done_q;
  assign obusy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_sar_adc.sv
// ============================================================================
// tb_pwm_sar_adc : scoreboard bench with an ideal RC filter + comparator model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pwm_sar_adc;

  localparam int S        = 2;
  localparam int CONV_CYC = 8 * S * 256;

  logic       iclk = 1'b0;
  logic       irstn = 1'b0;
  logic       ienable = 1'b0;
  logic       icomp;
  logic       opwm;
  logic [7:0] pwm_adc_out;
  logic       odone;
  logic       obusy;

  logic [7:0] vin = 8'h00;
  int         filt = 0;

  // Ideal filter: voltage equals the high time of the last complete period.
  assign icomp = (int'(vin) >= filt);

  always #5 iclk = ~iclk;

  pwm_sar_adc #(.SETTLE_PERIODS(S)) dut (
    .iclk        (iclk),
    .irstn       (irstn),
    .ienable     (ienable),
    .icomp       (icomp),
    .opwm        (opwm),
    .pwm_adc_out (pwm_adc_out),
    .odone       (odone),
    .obusy       (obusy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ph;
  always @(posedge iclk or negedge irstn) begin
    if (!irstn) ph <= 8'd0;
    else        ph <= ph + 8'd1;
  end

  logic [7:0] exp_q[$];
  int         pc_q[$];
  int         cyc = 0, hi = 0, last_count = -1;
  int         done_cnt = 0, done_cyc = 0, last_done_cyc = -1, t0 = -1;
  bit         shape_ok = 1'b1, prev = 1'b0, arm_pc = 1'b0, gap_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: PWM period measurement, shape check and odone scoreboard.
  initial begin
    forever begin
      @(negedge iclk);
      cyc++;
      if (!irstn) begin
        hi = 0;
        prev = 1'b0;
        shape_ok = 1'b1;
      end else begin
        if (ph == 8'd0) begin
          hi = int'(opwm);
          shape_ok = 1'b1;
        end else begin
          hi = hi + int'(opwm);
          if (opwm && !prev) shape_ok = 1'b0;
        end
        prev = opwm;
        if (arm_pc && obusy && ph == 8'd0 && t0 < 0) t0 = cyc;
        if (ph == 8'd255) begin
          last_count = hi;
          filt = hi;
          check("pwm_shape", 32'(shape_ok), 32'd1);
          if (arm_pc && obusy && pc_q.size() < 16) pc_q.push_back(hi);
        end
        if (odone) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got odone=1 result 0x%0h expected no pulse", pwm_adc_out);
          end else begin
            check("result", 32'(pwm_adc_out), 32'(exp_q.pop_front()));
          end
          if (gap_chk && last_done_cyc >= 0)
            check("done_gap", 32'(cyc - last_done_cyc), 32'(CONV_CYC));
          last_done_cyc = cyc;
          done_cyc = cyc;
          done_cnt++;
        end
      end
    end
  end

  task automatic wait_done(input int limit);
    int st;
    int n;
    st = done_cnt;
    n = 0;
    while (done_cnt == st && n < limit) begin
      @(negedge iclk);
      n++;
    end
    if (done_cnt == st) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no odone in %0d cycles expected one", limit);
    end
  endtask

  task automatic wait_busy(input int limit);
    int n;
    n = 0;
    while (!obusy && n < limit) begin
      @(negedge iclk);
      n++;
    end
    if (!obusy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got obusy=0 after %0d cycles expected 1", limit);
    end
  endtask

  initial begin
    int exp_trial;

    repeat (3) @(negedge iclk);
    check("rst_opwm", 32'(opwm), 32'd0);
    check("rst_out", 32'(pwm_adc_out), 32'd0);
    check("rst_done", 32'(odone), 32'd0);
    check("rst_busy", 32'(obusy), 32'd0);
    irstn = 1'b1;

    // Mid-scale conversion with trial sequence capture.
    @(negedge iclk);
    vin = 8'h5A;
    arm_pc = 1'b1;
    exp_q.push_back(8'h5A);
    ienable = 1'b1;
    wait_done(CONV_CYC + 600);
    check("first_latency", 32'(done_cyc - t0), 32'(CONV_CYC));
    check("trial_count", 32'(pc_q.size()), 32'd16);
    for (int i = 0; i < pc_q.size(); i++) begin
      int w;
      w = i / S;
      exp_trial = ((int'(vin) >> (8 - w)) << (8 - w)) | (8'h80 >> w);
      check("trial_seq", 32'(pc_q[i]), 32'(exp_trial));
    end
    arm_pc = 1'b0;

    // Continuous conversions with changing input, including extremes.
    gap_chk = 1'b1;
    vin = 8'hC3;
    exp_q.push_back(8'hC3);
    wait_done(CONV_CYC + 10);
    vin = 8'h00;
    exp_q.push_back(8'h00);
    wait_done(CONV_CYC + 10);
    for (int k = 0; k < 2; k++) begin
      vin = 8'($urandom_range(1, 254));
      exp_q.push_back(vin);
      wait_done(CONV_CYC + 10);
    end
    vin = 8'hFF;
    exp_q.push_back(8'hFF);
    wait_done(CONV_CYC + 10);
    ienable = 1'b0;
    gap_chk = 1'b0;
    @(negedge iclk);
    @(negedge iclk);
    check("stop_busy", 32'(obusy), 32'd0);
    repeat (3 * 256) @(negedge iclk);
    check("duty_ff_high", 32'(last_count), 32'd255);
    check("hold_ff", 32'(pwm_adc_out), 32'hFF);

    // Abort during bit 4.
    vin = 8'h33;
    ienable = 1'b1;
    wait_busy(600);
    repeat (3 * S * 256 + 100) @(negedge iclk);
    ienable = 1'b0;
    @(negedge iclk);
    check("abort_busy_fall", 32'(obusy), 32'd0);
    repeat (3 * 256) @(negedge iclk);
    check("abort_hold", 32'(pwm_adc_out), 32'hFF);
    check("abort_duty", 32'(last_count), 32'd255);

    // Asynchronous reset during bit 2, then a clean conversion.
    vin = 8'h96;
    ienable = 1'b1;
    wait_busy(600);
    repeat (5 * S * 256 + 50) @(negedge iclk);
    #2 irstn = 1'b0;
    #1;
    check("arst_opwm", 32'(opwm), 32'd0);
    check("arst_out", 32'(pwm_adc_out), 32'd0);
    check("arst_done", 32'(odone), 32'd0);
    check("arst_busy", 32'(obusy), 32'd0);
    @(negedge iclk);
    @(negedge iclk);
    irstn = 1'b1;
    exp_q.push_back(8'h96);
    wait_done(CONV_CYC + 600);
    ienable = 1'b0;
    repeat (4) @(negedge iclk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_sar_adc.md
# pwm_sar_adc

Successive-approximation ADC built from a PWM DAC and an external analog comparator. It produces the 8-bit `pwm_adc_out` code that the frequency-word accumulator loads into its low, mid or high frequency-byte field. The block drives a PWM pin into an external RC low-pass filter and samples the comparator output, which compares the filtered voltage against the potentiometer voltage. It resolves one bit per settle window, MSB first.

## Interface
- `SETTLE_PERIODS`, default 16: number of full PWM periods each bit trial is held before sampling. Legal range 1..255.
- `iclk`, input, 1 bit: system clock.
- `irstn`, input, 1 bit: reset, asynchronous, active-low.
- `ienable`, input, 1 bit: level input. High means convert continuously; low means abort the current conversion and idle.
- `icomp`, input, 1 bit: asynchronous comparator output. 1 means the analog input is at or above the filtered PWM voltage.
- `opwm`, output, 1 bit: PWM DAC drive to the RC filter.
- `pwm_adc_out`, output, 8 bits: last completed conversion result.
- `odone`, output, 1 bit: one-cycle pulse when `pwm_adc_out` updates.
- `obusy`, output, 1 bit: high while a conversion is in progress.

## Operation
- **PWM counter `cnt`.** 8 bits, free-running 0..255, wraps to 0.
  - `opwm = (cnt < duty_sh)`.
  - Duty 0x00 gives a constant low; 0xFF gives 255 high clocks out of 256.
- **Shadow duty.** `duty_sh` loads `duty` only when `cnt == 255`. The new value takes effect at `cnt == 0`, so no partial periods are ever produced.
- **Comparator synchronizer.** `icomp` passes through a 2-FF synchronizer to give `comp_s`. All decisions use `comp_s`.
- **FSM states:** IDLE, CONV.
- **IDLE.**
  - `duty = pwm_adc_out`, so the filter tracks the last result.
  - `obusy = 0`.
  - If `ienable = 1` when `cnt == 255`: go to CONV with `trial = 8'h80`, `bit_idx = 7`, `per_cnt = 0`. `duty = trial` from the same edge.
- **CONV.**
  - `duty = trial`, `obusy = 1`.
  - `per_cnt` increments at every `cnt == 255`.
  - The sample point is `cnt == 255` with `per_cnt == SETTLE_PERIODS-1`. At that point:
    - `trial[bit_idx]` is kept if `comp_s == 1`, otherwise cleared.
    - If `bit_idx > 0`: set `trial[bit_idx-1]`, decrement `bit_idx`, clear `per_cnt`.
    - If `bit_idx == 0`: register the decided code into `pwm_adc_out` on the next edge and assert `odone` for one cycle on the cycle that follows the sample edge. If `ienable` is still 1, start the next conversion immediately (fresh `8'h80` trial); otherwise go to IDLE.
- **Abort.** `ienable = 0` in CONV returns to IDLE on the next edge. `pwm_adc_out` is unchanged and `odone` is not asserted.
- **Reset values:** `cnt = 0`, `duty_sh = 0`, `opwm = 0`, `pwm_adc_out = 8'h00`, `odone = 0`, `obusy = 0`, state IDLE, synchronizer flops 0.
- **Reset mid-conversion:** all state returns to reset values immediately (asynchronous). There is no partial result.

## Timing
- The PWM period is 256 iclk cycles.
- Each bit window is exactly `SETTLE_PERIODS × 256` cycles, aligned to PWM period boundaries.
- A conversion takes `8 × SETTLE_PERIODS × 256` cycles, measured from the `cnt == 0` that starts bit 7 to the bit-0 sample edge.
- `odone` is high during the cycle in which the new `pwm_adc_out` is first visible.
- Start latency from `ienable` rising is at most 256 cycles plus one.
- Comparator latency is 2 cycles. The sample point is the last clock of the window, so the synchronizer delay is absorbed.
- Back-to-back conversions have zero gap. The next bit-7 window starts at the `cnt == 0` immediately after the bit-0 sample.

## Structure
- **Shared package `dds_pkg`:**
  - state encoding (IDLE, CONV)
  - `PWM_PERIOD = 256`
  - `ADC_BITS = 8`
- **Sub-module `pwm_gen`:**
  - contains the free-running counter, the shadow duty register and the compare
  - outputs `opwm` and a `period_end` strobe (`cnt == 255`)
  - the SAR FSM consumes `period_end`.
- The synchronizer is inline, as two flops.

## Test plan
Use `SETTLE_PERIODS = 2` (4096 cycles per conversion). The bench comparator model is `icomp = (vin >= duty_sh)`, with an ideal filter.

- **Mid-scale input.** `vin = 8'h5A`, `ienable = 1` → trial sequence 80, 40, 60, 50, 58, 5C, 5A, 5B. `pwm_adc_out = 8'h5A` with a single `odone` pulse 4096 cycles after the first bit-7 period start.
- **Extremes.** `vin = 8'h00` → `8'h00`. `vin = 8'hFF` → `8'hFF`. Also check that duty 0xFF gives 255 high cycles out of 256 on `opwm`.
- **Continuous conversion with a changing input.** Hold `ienable = 1`; change `vin` 0x5A → 0xC3 between conversions → consecutive `odone` pulses exactly 4096 cycles apart, with results 0x5A then 0xC3.
- **Abort.** Drop `ienable` during bit 4 → `obusy` falls next cycle, no `odone`, `pwm_adc_out` keeps its previous value, and `opwm` duty equals that value from the next period.
- **Reset mid-conversion.** Pulse `irstn` low during bit 2 → `opwm`, `pwm_adc_out`, `odone` and `obusy` are 0 asynchronously. After release with `ienable = 1`, a full conversion yields the correct code.
- **Glitch-free duty change.** Check every PWM period: the high time equals `duty_sh`, and no period is truncated at a trial change.
